// File: rtl/pbus_irq_ctrl.sv
// pbus_irq_ctrl
//   Platform interrupt controller, one AXI-Lite slave in a 4 KiB window.
//   It collects up to 31 level-sensitive sources through a per-source gateway
//   (pending / in_service) and arbitrates them with fixed priority: lowest ID
//   wins. Source input bit i carries ID i+1, and ID 0 means "none".
//
//   Register map (decoded on address bits [11:2]):
//     0x00 PENDING  RO  bit ID = pending
//     0x04 ENABLE   RW  bit ID = enable (bit 0 and bits above NUM_SOURCES read 0)
//     0x08 CLAIM    R: claim the winning ID (0 if none)  W: complete that ID
//     0x0C CTRL     RW  bit0 GLOBAL_EN
//     other         read 0 / write ignored, SLVERR
//
//   Ports:
//     clock_i, reset_ni      clock, asynchronous active-low reset
//     irq_src_i              level-sensitive, active-high sources
//     ext_irq_o              registered request to the core
//     s_axilite_*            AXI-Lite slave (AW/W/B and AR/R channels)
//     dbg_w_state_o          write FSM state (0 W_IDLE, 1 W_RESP)
//     dbg_r_state_o          read FSM state  (0 R_IDLE, 1 R_RESP)
//
//   Handshake rule: a transfer happens on a rising edge where valid and ready
//   are both high. A valid, once raised, is held with its payload stable until
//   that edge.
//
//   Optional feature: define IRQ_CTRL_SYNC_EN to put a two-flop synchronizer
//   on every source (sampling depth 2). Without it the sources feed the
//   gateway directly and must be synchronous to clock_i.
module pbus_irq_ctrl #(
  parameter int NUM_SOURCES = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  output logic                   ext_irq_o,
  input  logic [ADDR_WIDTH-1:0]  s_axilite_awaddr,
  input  logic                   s_axilite_awvalid,
  output logic                   s_axilite_awready,
  input  logic [31:0]            s_axilite_wdata,
  input  logic [3:0]             s_axilite_wstrb,
  input  logic                   s_axilite_wvalid,
  output logic                   s_axilite_wready,
  output logic [1:0]             s_axilite_bresp,
  output logic                   s_axilite_bvalid,
  input  logic                   s_axilite_bready,
  input  logic [ADDR_WIDTH-1:0]  s_axilite_araddr,
  input  logic                   s_axilite_arvalid,
  output logic                   s_axilite_arready,
  output logic [31:0]            s_axilite_rdata,
  output logic [1:0]             s_axilite_rresp,
  output logic                   s_axilite_rvalid,
  input  logic                   s_axilite_rready,
  output logic                   dbg_w_state_o,
  output logic                   dbg_r_state_o
);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_e               w_state_q, w_state_d;
  r_state_e               r_state_q, r_state_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] in_service_q, in_service_d;
  logic [NUM_SOURCES-1:0] enable_q, enable_d;
  logic                   global_en_q, global_en_d;
  logic                   ext_irq_q, ext_irq_d;

  logic [NUM_SOURCES-1:0] level;
  logic [NUM_SOURCES-1:0] active, win_oh, claim_oh, cmp_oh;
  logic [4:0]             win_id;
  logic                   wr_hs, rd_hs, wr_mapped, rd_mapped, wr_apply;
  logic [9:0]             wr_idx, rd_idx;
  logic [31:0]            rd_word;
  logic                   unused_addr_bits;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SOURCES-1:0] sync1_q, sync2_q;
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end
  assign level = sync2_q;
`else
  assign level = irq_src_i;
`endif

  // Only the word index inside the 4 KiB window matters.
  assign unused_addr_bits = ^{s_axilite_awaddr[ADDR_WIDTH-1:12], s_axilite_awaddr[1:0],
                              s_axilite_araddr[ADDR_WIDTH-1:12], s_axilite_araddr[1:0],
                              s_axilite_wstrb[3:1]};

  assign wr_idx    = s_axilite_awaddr[11:2];
  assign rd_idx    = s_axilite_araddr[11:2];
  assign wr_mapped = (wr_idx[9:2] == 8'd0);
  assign rd_mapped = (rd_idx[9:2] == 8'd0);

  // AW and W are accepted together, only when both are offered.
  assign wr_hs    = (w_state_q == W_IDLE) && s_axilite_awvalid && s_axilite_wvalid;
  assign rd_hs    = (r_state_q == R_IDLE) && s_axilite_arvalid;
  assign wr_apply = wr_hs && s_axilite_wstrb[0];

  // Fixed priority: the lowest set bit of pending & enable wins.
  always_comb begin
    active = pending_q & enable_q;
    win_oh = active & (~active + 1'b1);
    win_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (active[i]) win_id = 5'(i + 1);
    end
  end

  always_comb begin
    claim_oh = (rd_hs && rd_idx == 10'd2) ? win_oh : '0;
    cmp_oh   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      cmp_oh[i] = wr_apply && (wr_idx == 10'd2) && (s_axilite_wdata == 32'(i + 1));
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      10'd0:   rd_word = 32'({pending_q, 1'b0});
      10'd1:   rd_word = 32'({enable_q, 1'b0});
      10'd2:   rd_word = 32'(win_id);
      10'd3:   rd_word = {31'd0, global_en_q};
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    // The set term uses pre-edge pending/in_service, so a source completed in
    // this cycle can only re-pend on the following edge.
    pending_d    = (pending_q & ~claim_oh) | (level & ~in_service_q & ~pending_q);
    in_service_d = (in_service_q & ~cmp_oh) | claim_oh;
    enable_d     = enable_q;
    global_en_d  = global_en_q;
    if (wr_apply && wr_idx == 10'd1) enable_d    = s_axilite_wdata[NUM_SOURCES:1];
    if (wr_apply && wr_idx == 10'd3) global_en_d = s_axilite_wdata[0];
    ext_irq_d = global_en_q && (|active);
  end

  always_comb begin
    w_state_d = w_state_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: if (wr_hs) begin
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
        bresp_d   = wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: if (s_axilite_bready) begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (rd_hs) begin
        r_state_d = R_RESP;
        rvalid_d  = 1'b1;
        rresp_d   = rd_mapped ? RESP_OKAY : RESP_SLVERR;
        rdata_d   = rd_mapped ? rd_word : 32'd0;
      end
      R_RESP: if (s_axilite_rready) begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      global_en_q  <= 1'b0;
      ext_irq_q    <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      global_en_q  <= global_en_d;
      ext_irq_q    <= ext_irq_d;
    end
  end

  assign s_axilite_awready = wr_hs;
  assign s_axilite_wready  = wr_hs;
  assign s_axilite_bvalid  = bvalid_q;
  assign s_axilite_bresp   = bresp_q;
  assign s_axilite_arready = (r_state_q == R_IDLE);
  assign s_axilite_rvalid  = rvalid_q;
  assign s_axilite_rresp   = rresp_q;
  assign s_axilite_rdata   = rdata_q;
  assign ext_irq_o         = ext_irq_q;
  assign dbg_w_state_o     = w_state_q;
  assign dbg_r_state_o     = r_state_q;

endmodule

// File: doc/pbus_irq_ctrl.md
# pbus_irq_ctrl

Platform interrupt controller on the AXI-Lite peripheral bus. It gathers up to 31 level-sensitive external interrupt sources and arbitrates among them with fixed priority. It drives the core's external-interrupt line (pin EXT_INT_PIN of the core interrupt vector), and software claims and completes sources through a claim/complete register. It is one PBUS slave, occupying a 4 KiB window.

## Interface

**Parameters**
- NUM_SOURCES, default 8: number of interrupt sources, range 1..31. Source input bit i has ID i+1; ID 0 means "none".
- ADDR_WIDTH, default 32: AXI-Lite address width. Only bits [11:0] are decoded.

**Ports**
- clock_i, in, 1: system clock.
- reset_ni, in, 1: reset. Asynchronous, active-low.
- irq_src_i, in, NUM_SOURCES: level-sensitive, active-high source lines.
- ext_irq_o, out, 1: external interrupt request to the core. Registered.
- s_axilite_awaddr, in, ADDR_WIDTH / s_axilite_awvalid, in, 1 / s_axilite_awready, out, 1.
- s_axilite_wdata, in, 32 / s_axilite_wstrb, in, 4 / s_axilite_wvalid, in, 1 / s_axilite_wready, out, 1.
- s_axilite_bresp, out, 2 / s_axilite_bvalid, out, 1 / s_axilite_bready, in, 1.
- s_axilite_araddr, in, ADDR_WIDTH / s_axilite_arvalid, in, 1 / s_axilite_arready, out, 1.
- s_axilite_rdata, out, 32 / s_axilite_rresp, out, 2 / s_axilite_rvalid, out, 1 / s_axilite_rready, in, 1.

## Operation

**Register map**
- 0x00 PENDING, RO: bit ID set when that source is pending.
- 0x04 ENABLE, RW: per-ID enable; bit 0 and bits above NUM_SOURCES are read-only 0.
- 0x08 CLAIM/COMPLETE:
  - Read returns the winning ID, or 0.
  - Write of ID completes that source.
- 0x0C CTRL, RW: bit0 GLOBAL_EN. All other bits are read-only 0.
- Offsets 0x10..0xFFC: reads return 0 with SLVERR; writes are ignored with SLVERR. Mapped offsets respond OKAY.
- Write data is applied only when wstrb[0] is set; the upper strobes are ignored.

**Gateway, per source**
- pending[ID] sets when the sampled level is high AND in_service[ID]=0 AND pending[ID]=0.
- A claim clears pending[ID] and sets in_service[ID].
- A complete write clears in_service[ID]. Completing a source that is not in service is a no-op and still returns OKAY.
- If the level is still high after completion, pending re-sets on the next cycle.

**Arbitration**
- Winner = lowest ID with pending & enable set. Otherwise 0.
- GLOBAL_EN does not affect the claim result.
- ext_irq_o next = GLOBAL_EN & |(pending & enable).

**Write FSM: W_IDLE, W_RESP**
- In W_IDLE, awready and wready are asserted together only when awvalid & wvalid. The register update happens on that handshake edge, and the FSM moves to W_RESP.
- W_RESP holds bvalid until bready, then returns to W_IDLE.

**Read FSM: R_IDLE, R_RESP**
- In R_IDLE, arready=1. On the handshake, rdata and rresp are latched and the FSM moves to R_RESP.
- R_RESP holds rvalid and a stable rdata until rready.
- The claim side-effect is applied exactly once, on the AR handshake edge.

**Concurrency**
- Read and write channels are independent; one of each may be in flight.
- A complete and a claim in the same cycle are both applied.
- Gateway set uses the in_service and pending values from before the edge. A same-cycle complete therefore cannot re-pend until the next cycle.

## Timing

- Reset values: all AXI valid/ready outputs 0, except arready, which is 1 in R_IDLE. bresp/rresp 0, rdata 0, ext_irq_o 0. pending, in_service and ENABLE are all 0; GLOBAL_EN is 0.
- Sampling depth is S = 2 with IRQ_CTRL_SYNC_EN defined, 0 without.
  - Source rise at edge k sets pending at edge k+S.
  - ext_irq_o asserts at edge k+S+1.
- Read latency: rvalid is asserted the cycle after the AR handshake.
- Write latency: bvalid is asserted the cycle after the AW/W handshake.
- ext_irq_o deasserts one cycle after the edge where the claim clears the last enabled pending bit.
- Reset assertion mid-transaction aborts it immediately; all state returns to reset values with no response issued.

## Configuration

- IRQ_CTRL_SYNC_EN
  - Defined: each irq_src_i bit passes through a two-flop synchronizer (reset to 0) before the gateway. Used for asynchronous sources.
  - Undefined: irq_src_i feeds the gateway directly (S = 0). Sources must then be synchronous to clock_i.

## Test plan

- Reset, then read 0x00/0x04/0x08/0x0C → all 0, OKAY. ext_irq_o=0, arready=1.
- ENABLE=0x6, GLOBAL_EN=1, irq_src_i=0x3 → ext_irq_o=1 after S+1 edges. Read 0x08 → 1; read 0x08 → 2; read 0x08 → 0; ext_irq_o=0.
- Source 1 held high, claimed, then write 1 to 0x08 → PENDING bit1 re-sets the next cycle and ext_irq_o reasserts.
- Pending with GLOBAL_EN=0 → ext_irq_o stays 0 and a claim still returns the ID. Set GLOBAL_EN=1 → ext_irq_o=1 next cycle.
- Read 0x10 and write 0x100 → SLVERR; rdata=0; no state change. Stall bready/rready 5 cycles → bvalid/rvalid/rdata remain stable.
- Assert reset_ni=0 while in R_RESP with rvalid=1 → rvalid drops immediately and pending/in_service clear.
